gpio_write_arbiter: RTL and testbench
=====================================

# gpio_write_arbiter

Sequential arbiter that shares the GPIO pin-write and pindir-write resource among four state machines. Each SM issues masked write requests over a valid/ready handshake. Requests with disjoint masks are merged and applied in the same cycle. Overlapping requests are resolved by a rotating priority pointer that is starvation-free. Output is a registered, merged write bus toward the GPIO bank, with sticky pin-direction state held inside the block.

## Interface
- Parameters:
- NUM_SM, 4, number of requesters (fixed at 4 for this revision)
- WIDTH, 32, GPIO pin count
- CNT_W, 16, conflict counter width
- Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_smEnable  in  4  per-SM enable; a disabled SM is ignored (ready=0)
- in_reqValid  in  4  request valid, bit n = SM n
- in_reqIsDir  in  4  1 = pindirs write, 0 = pins write
- in_reqData  in  4*WIDTH  SM n data at [WIDTH*n +: WIDTH]
- in_reqMask  in  4*WIDTH  SM n mask, same packing
- out_reqReady  out  4  accept strobe; combinational from valid/mask/pointer
- out_pinsWriteData  out  WIDTH  registered merged pin data (masked bits only)
- out_pinsWriteMask  out  WIDTH  registered merged pin mask
- out_pinDirsWriteData  out  WIDTH  sticky pindir state register
- out_pinDirsWriteMask  out  WIDTH  registered merged pindir mask
- out_conflictCount  out  CNT_W  saturating count of conflict cycles
- out_priorityPtr  out  2  current highest-priority SM

## Operation
- Request n is *live* when in_reqValid[n] & in_smEnable[n].
- Evaluation order each cycle: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Two accumulators run along that order, accPins and accDirs, both starting at 0.
- A live request is accepted if (mask & acc[type]) == 0. On acceptance, acc[type] |= mask and out_reqReady[n]=1.
- Otherwise the request is rejected: ready=0, and the SM must hold valid/data/mask/isDir stable until accepted.
- Zero-mask live request: always accepted, no pin effect.
- Pins and pindirs requests never conflict with each other.
- Merge: the data bit for each pin comes from the single accepted request owning that bit. Masks are disjoint, so the merge is an OR of (data & mask).
- Pointer update:
  - If any live request was rejected, ptr <= index of the first rejected request in evaluation order.
  - Otherwise ptr is unchanged.
  - This guarantees a rejected SM wins within 1 cycle if it holds its request.
- Pindir state: dirState <= (dirState & ~accDirs) | mergedDirData. Unwritten bits keep their prior value.
- out_conflictCount increments by 1 in every cycle with at least one rejection, saturating at 2^CNT_W-1.
- Deasserting in_smEnable mid-request drops that request. No acceptance is recorded and nothing is written.

## Timing
- Handshake completes in the cycle where valid & ready are both high. Ready may depend on the same-cycle valid; valid must not depend on ready.
- Write latency is 1 cycle: a request accepted in cycle t appears on out_pinsWrite*/out_pinDirsWriteMask in cycle t+1. out_pinDirsWriteData reflects the updated dirState in t+1.
- Idle cycle (nothing accepted): both masks register 0 and pin data registers 0; dirState holds.
- Reset (async assert, any cycle, including mid-conflict):
  - all outputs 0, ptr=0, dirState=0, counter=0
  - out_reqReady=0 while reset is high
  - in-flight requests are discarded.
- First cycle after reset release evaluates with ptr=0.
- Throughput: up to 4 accepts per cycle when masks are disjoint.

## Test plan
- SM0 pins mask 0x0000_00FF data 0xA5, SM1 pins mask 0x0000_FF00 data 0x3C00, same cycle, ptr=0 -> both ready; next cycle out_pinsWriteMask=0x0000_FFFF, out_pinsWriteData=0x0000_3CA5, counter stays 0.
- SM0 and SM2 pins, both mask 0x1, ptr=0 -> SM0 ready, SM2 rejected, ptr->2, counter=1. Next cycle SM2 accepted, ptr stays 2.
- SM3 pindirs mask 0xF data 0xF, then SM1 pindirs mask 0x3 data 0x0 -> out_pinDirsWriteData 0xF then 0xC; idle cycles hold 0xC with out_pinDirsWriteMask=0.
- SM1 pins mask 0x10 plus SM2 pindirs mask 0x10, same cycle -> both accepted (different types), no conflict counted.
- All four SMs request overlapping pins mask 0x1 continuously -> grants rotate with each SM accepted once per 4 cycles (order 0,1,2,3,…), counter increments every cycle and saturates at 0xFFFF.
- Assert reset during a conflict with ptr=3 and dirState=0xFF -> all outputs 0 and ptr 0 immediately. After release, the first live SM0 request is accepted.

Source files
------------

// File: rtl/gpio_write_arbiter.sv
// Arbitrates masked GPIO pin and pindir writes from four state machines onto one shared write bus.
// Latency: a write accepted in cycle t is presented on the write outputs in cycle t+1.
// Backpressure: overlapping requests are refused per cycle; the first refused SM takes top priority next cycle.
module gpio_write_arbiter #(
    parameter int NUM_SM = 4,
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SM-1:0]       in_smEnable,
    input  logic [NUM_SM-1:0]       in_reqValid,
    input  logic [NUM_SM-1:0]       in_reqIsDir,
    input  logic [NUM_SM*WIDTH-1:0] in_reqData,
    input  logic [NUM_SM*WIDTH-1:0] in_reqMask,
    output logic [NUM_SM-1:0]       out_reqReady,
    output logic [WIDTH-1:0]        out_pinsWriteData,
    output logic [WIDTH-1:0]        out_pinsWriteMask,
    output logic [WIDTH-1:0]        out_pinDirsWriteData,
    output logic [WIDTH-1:0]        out_pinDirsWriteMask,
    output logic [CNT_W-1:0]        out_conflictCount,
    output logic [1:0]              out_priorityPtr
);

    logic [NUM_SM-1:0] live;
    logic [NUM_SM-1:0] grant;
    logic [WIDTH-1:0]  acc_pins;
    logic [WIDTH-1:0]  acc_dirs;
    logic [WIDTH-1:0]  pins_data;
    logic [WIDTH-1:0]  dirs_data;
    logic [WIDTH-1:0]  req_mask;
    logic [WIDTH-1:0]  req_data;
    logic [1:0]        idx;
    logic              rej_found;
    logic [1:0]        rej_idx;

    logic [WIDTH-1:0]  pins_data_q;
    logic [WIDTH-1:0]  pins_mask_q;
    logic [WIDTH-1:0]  dirs_mask_q;
    logic [WIDTH-1:0]  dir_state;
    logic [CNT_W-1:0]  conflict_cnt;
    logic [1:0]        ptr;

    assign live = in_reqValid & in_smEnable;

    // Walk the requesters in rotating priority order, granting each one whose mask
    // does not collide with bits already claimed by a higher-priority grant of its type.
    always_comb begin
        grant     = '0;
        acc_pins  = '0;
        acc_dirs  = '0;
        pins_data = '0;
        dirs_data = '0;
        req_mask  = '0;
        req_data  = '0;
        idx       = '0;
        rej_found = 1'b0;
        rej_idx   = ptr;
        for (int k = 0; k < NUM_SM; k++) begin
            idx      = ptr + 2'(k);
            req_mask = in_reqMask[WIDTH*idx +: WIDTH];
            req_data = in_reqData[WIDTH*idx +: WIDTH];
            if (live[idx]) begin
                if (in_reqIsDir[idx] && ((req_mask & acc_dirs) == '0)) begin
                    grant[idx] = 1'b1;
                    acc_dirs   = acc_dirs | req_mask;
                    dirs_data  = dirs_data | (req_data & req_mask);
                end else if (!in_reqIsDir[idx] && ((req_mask & acc_pins) == '0)) begin
                    grant[idx] = 1'b1;
                    acc_pins   = acc_pins | req_mask;
                    pins_data  = pins_data | (req_data & req_mask);
                end else if (!rej_found) begin
                    rej_found = 1'b1;
                    rej_idx   = idx;
                end
            end
        end
    end

    assign out_reqReady = reset ? '0 : grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pins_data_q  <= '0;
            pins_mask_q  <= '0;
            dirs_mask_q  <= '0;
            dir_state    <= '0;
            conflict_cnt <= '0;
            ptr          <= '0;
        end else begin
            pins_data_q <= pins_data;
            pins_mask_q <= acc_pins;
            dirs_mask_q <= acc_dirs;
            dir_state   <= (dir_state & ~acc_dirs) | dirs_data;
            if (rej_found) begin
                ptr <= rej_idx;
                if (conflict_cnt != '1) begin
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_pinsWriteData    = pins_data_q;
    assign out_pinsWriteMask    = pins_mask_q;
    assign out_pinDirsWriteData = dir_state;
    assign out_pinDirsWriteMask = dirs_mask_q;
    assign out_conflictCount    = conflict_cnt;
    assign out_priorityPtr      = ptr;

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// Directed bench for gpio_write_arbiter; a narrow conflict counter lets saturation be reached quickly.
module tb_gpio_write_arbiter;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       in_smEnable;
    logic [3:0]       in_reqValid;
    logic [3:0]       in_reqIsDir;
    logic [4*WIDTH-1:0] in_reqData;
    logic [4*WIDTH-1:0] in_reqMask;
    logic [3:0]       out_reqReady;
    logic [WIDTH-1:0] out_pinsWriteData;
    logic [WIDTH-1:0] out_pinsWriteMask;
    logic [WIDTH-1:0] out_pinDirsWriteData;
    logic [WIDTH-1:0] out_pinDirsWriteMask;
    logic [CNT_W-1:0] out_conflictCount;
    logic [1:0]       out_priorityPtr;

    int errors = 0;
    int checks = 0;

    gpio_write_arbiter #(.NUM_SM(4), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_smEnable          (in_smEnable),
        .in_reqValid          (in_reqValid),
        .in_reqIsDir          (in_reqIsDir),
        .in_reqData           (in_reqData),
        .in_reqMask           (in_reqMask),
        .out_reqReady         (out_reqReady),
        .out_pinsWriteData    (out_pinsWriteData),
        .out_pinsWriteMask    (out_pinsWriteMask),
        .out_pinDirsWriteData (out_pinDirsWriteData),
        .out_pinDirsWriteMask (out_pinDirsWriteMask),
        .out_conflictCount    (out_conflictCount),
        .out_priorityPtr      (out_priorityPtr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        in_reqValid = '0;
        in_reqIsDir = '0;
        in_reqData  = '0;
        in_reqMask  = '0;
    endtask

    task automatic req(input int n, input logic is_dir, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] m);
        in_reqValid[n]              = 1'b1;
        in_reqIsDir[n]              = is_dir;
        in_reqData[WIDTH*n +: WIDTH] = d;
        in_reqMask[WIDTH*n +: WIDTH] = m;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]       exp_ptr;
        logic [CNT_W-1:0] exp_cnt;

        reset       = 1'b1;
        in_smEnable = 4'hF;
        clear_reqs();
        req(0, 1'b0, 32'h1, 32'h1);
        #2;
        chk("reset_ready",    64'(out_reqReady), 64'h0);
        chk("reset_pmask",    64'(out_pinsWriteMask), 64'h0);
        chk("reset_pdata",    64'(out_pinsWriteData), 64'h0);
        chk("reset_dirdata",  64'(out_pinDirsWriteData), 64'h0);
        chk("reset_dirmask",  64'(out_pinDirsWriteMask), 64'h0);
        chk("reset_cnt",      64'(out_conflictCount), 64'h0);
        chk("reset_ptr",      64'(out_priorityPtr), 64'h0);
        clear_reqs();
        tick();
        reset = 1'b0;

        // Disjoint pin writes merge in one cycle.
        req(0, 1'b0, 32'h0000_00A5, 32'h0000_00FF);
        req(1, 1'b0, 32'h0000_3C00, 32'h0000_FF00);
        #1;
        chk("merge_ready", 64'(out_reqReady), 64'h3);
        tick();
        chk("merge_pmask", 64'(out_pinsWriteMask), 64'h0000_FFFF);
        chk("merge_pdata", 64'(out_pinsWriteData), 64'h0000_3CA5);
        chk("merge_cnt",   64'(out_conflictCount), 64'h0);
        chk("merge_dmask", 64'(out_pinDirsWriteMask), 64'h0);
        clear_reqs();

        // SM0 vs SM2 on pin 0: SM0 wins, SM2 takes priority next cycle.
        req(0, 1'b0, 32'h1, 32'h1);
        req(2, 1'b0, 32'h0, 32'h1);
        #1;
        chk("conf_ready0", 64'(out_reqReady), 64'h1);
        tick();
        chk("conf_ptr0",   64'(out_priorityPtr), 64'h2);
        chk("conf_cnt0",   64'(out_conflictCount), 64'h1);
        chk("conf_pmask0", 64'(out_pinsWriteMask), 64'h1);
        chk("conf_pdata0", 64'(out_pinsWriteData), 64'h1);
        in_reqValid[0] = 1'b0;
        #1;
        chk("conf_ready1", 64'(out_reqReady), 64'h4);
        tick();
        chk("conf_ptr1",   64'(out_priorityPtr), 64'h2);
        chk("conf_cnt1",   64'(out_conflictCount), 64'h1);
        chk("conf_pmask1", 64'(out_pinsWriteMask), 64'h1);
        chk("conf_pdata1", 64'(out_pinsWriteData), 64'h0);
        clear_reqs();

        // Sticky pindir state.
        req(3, 1'b1, 32'hF, 32'hF);
        #1;
        chk("dir_ready0", 64'(out_reqReady), 64'h8);
        tick();
        chk("dir_data0",  64'(out_pinDirsWriteData), 64'hF);
        chk("dir_mask0",  64'(out_pinDirsWriteMask), 64'hF);
        chk("dir_pmask0", 64'(out_pinsWriteMask), 64'h0);
        clear_reqs();
        req(1, 1'b1, 32'h0, 32'h3);
        tick();
        chk("dir_data1", 64'(out_pinDirsWriteData), 64'hC);
        chk("dir_mask1", 64'(out_pinDirsWriteMask), 64'h3);
        clear_reqs();
        tick();
        chk("idle_dirdata", 64'(out_pinDirsWriteData), 64'hC);
        chk("idle_dirmask", 64'(out_pinDirsWriteMask), 64'h0);
        chk("idle_pmask",   64'(out_pinsWriteMask), 64'h0);
        chk("idle_pdata",   64'(out_pinsWriteData), 64'h0);

        // Same bit, different types: no conflict.
        req(1, 1'b0, 32'h10, 32'h10);
        req(2, 1'b1, 32'h10, 32'h10);
        #1;
        chk("type_ready", 64'(out_reqReady), 64'h6);
        tick();
        chk("type_pmask",   64'(out_pinsWriteMask), 64'h10);
        chk("type_pdata",   64'(out_pinsWriteData), 64'h10);
        chk("type_dirmask", 64'(out_pinDirsWriteMask), 64'h10);
        chk("type_dirdata", 64'(out_pinDirsWriteData), 64'h1C);
        chk("type_cnt",     64'(out_conflictCount), 64'h1);
        clear_reqs();

        // Zero-mask request is accepted and writes nothing.
        req(0, 1'b0, 32'hFFFF, 32'h0);
        req(1, 1'b0, 32'h5, 32'hF);
        #1;
        chk("zmask_ready", 64'(out_reqReady), 64'h3);
        tick();
        chk("zmask_pmask", 64'(out_pinsWriteMask), 64'hF);
        chk("zmask_pdata", 64'(out_pinsWriteData), 64'h5);
        clear_reqs();

        // Disabled SM is ignored.
        in_smEnable = 4'hE;
        req(0, 1'b0, 32'h1, 32'h1);
        #1;
        chk("dis_ready", 64'(out_reqReady), 64'h0);
        tick();
        chk("dis_pmask", 64'(out_pinsWriteMask), 64'h0);
        in_smEnable = 4'hF;
        clear_reqs();

        req(0, 1'b1, 32'hFF, 32'hFF);
        tick();
        chk("dirff_data", 64'(out_pinDirsWriteData), 64'hFF);
        clear_reqs();

        // All four fight over pin 0: grants rotate, counter saturates.
        for (int n = 0; n < 4; n++) req(n, 1'b0, 32'h1, 32'h1);
        exp_ptr = 2'd2;
        exp_cnt = CNT_W'(1);
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("rot_ready", 64'(out_reqReady), 64'(4'b0001 << exp_ptr));
            tick();
            exp_ptr = exp_ptr + 2'd1;
            if (exp_cnt != '1) exp_cnt = exp_cnt + CNT_W'(1);
            chk("rot_ptr", 64'(out_priorityPtr), 64'(exp_ptr));
            chk("rot_cnt", 64'(out_conflictCount), 64'(exp_cnt));
        end
        chk("rot_final_ptr", 64'(out_priorityPtr), 64'h3);
        chk("rot_final_cnt", 64'(out_conflictCount), 64'hF);
        chk("rot_dirdata",   64'(out_pinDirsWriteData), 64'hFF);

        // Asynchronous reset mid-conflict.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ready",   64'(out_reqReady), 64'h0);
        chk("arst_ptr",     64'(out_priorityPtr), 64'h0);
        chk("arst_cnt",     64'(out_conflictCount), 64'h0);
        chk("arst_dirdata", 64'(out_pinDirsWriteData), 64'h0);
        chk("arst_pmask",   64'(out_pinsWriteMask), 64'h0);
        chk("arst_pdata",   64'(out_pinsWriteData), 64'h0);
        chk("arst_dirmask", 64'(out_pinDirsWriteMask), 64'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_ready", 64'(out_reqReady), 64'h1);
        tick();
        chk("post_ptr",     64'(out_priorityPtr), 64'h1);
        chk("post_cnt",     64'(out_conflictCount), 64'h1);
        chk("post_pmask",   64'(out_pinsWriteMask), 64'h1);
        chk("post_dirdata", 64'(out_pinDirsWriteData), 64'h0);
        clear_reqs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
